// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM state type, default width and count-width helper for seq_divider
package seq_divider_pkg;
   localparam int DIV_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division trial subtract on a generate/propagate carry chain
//   rem_sh_i   WIDTH+1  shifted partial remainder
//   dvsr_i     WIDTH    divisor magnitude
//   next_rem_o WIDTH    remainder after this step
//   q_bit_o    1        quotient bit (1 when the subtraction did not borrow)
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_sh_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] next_rem_o,
   output logic             q_bit_o
);
   logic [WIDTH:0] nb, g, p, c, diff;
   assign nb = ~{1'b0, dvsr_i};
   assign g  = rem_sh_i & nb;
   assign p  = rem_sh_i ^ nb;
   // subtract as a + ~b + 1: carry-in of one at bit 0
   always_comb begin
      c = '0;
      c[0] = 1'b1;
      for (int k = 0; k < WIDTH; k++) c[k+1] = g[k] | (p[k] & c[k]);
   end
   assign diff       = p ^ c;
   assign q_bit_o    = ~diff[WIDTH];
   assign next_rem_o = q_bit_o ? diff[WIDTH-1:0] : rem_sh_i[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for DIV/DIVU (LO=quotient, HI=remainder)
//   clk, reset (async, active-high); start, is_signed, dividend, divisor in;
//   busy, done, quotient, remainder, div_by_zero out
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = cnt_width(WIDTH);
   div_state_t     state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d, dbz_out_q, dbz_out_d;
   logic [WIDTH-1:0] next_rem;
   logic             q_bit, a_neg, b_neg;
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_sh_i   ({rem_q, quo_q[WIDTH-1]}),
      .dvsr_i     (dvsr_q),
      .next_rem_o (next_rem),
      .q_bit_o    (q_bit)
   );
   assign a_neg = is_signed & dividend[WIDTH-1];
   assign b_neg = is_signed & divisor[WIDTH-1];
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      cnt_d       = cnt_q;
      sq_d        = sq_q;
      sr_d        = sr_q;
      dbz_d       = dbz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_out_d   = dbz_out_q;
      case (state_q)
         IDLE: if (start) begin
            dbz_d   = divisor == '0;
            // on divide-by-zero the raw dividend rides in quo_q to become the remainder
            quo_d   = dbz_d ? dividend : (a_neg ? -dividend : dividend);
            dvsr_d  = b_neg ? -divisor : divisor;
            rem_d   = '0;
            sq_d    = a_neg ^ b_neg;
            sr_d    = a_neg;
            cnt_d   = CW'(WIDTH);
            state_d = dbz_d ? FIX : RUN;
         end
         RUN: begin
            rem_d   = next_rem;
            quo_d   = {quo_q[WIDTH-2:0], q_bit};
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? FIX : RUN;
         end
         FIX: begin
            quotient_d  = dbz_q ? '1 : (sq_q ? -quo_q : quo_q);
            remainder_d = dbz_q ? quo_q : (sr_q ? -rem_q : rem_q);
            dbz_out_d   = dbz_q;
            state_d     = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         cnt_q       <= '0;
         sq_q        <= 1'b0;
         sr_q        <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         cnt_q       <= cnt_d;
         sq_q        <= sq_d;
         sr_q        <= sr_d;
         dbz_q       <= dbz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_out_q   <= dbz_out_d;
      end
   end
   assign busy        = state_q == RUN || state_q == FIX;
   assign done        = state_q == DONE;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;
   int          tests = 0;
   int          errors = 0;
   seq_divider dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );
   always #5 clk = ~clk;
   // pulse start for one cycle; lat = cycle index (start cycle = 0) where done is seen
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
      @(negedge clk);
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
      int lat;
      run_op(a, b, s, lat);
      tests++;
      if (lat !== elat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat); end
      tests++;
      if (quotient !== eq) begin errors++; $display("FAIL %s quotient: got %h expected %h", name, quotient, eq); end
      tests++;
      if (remainder !== er) begin errors++; $display("FAIL %s remainder: got %h expected %h", name, remainder, er); end
      tests++;
      if (div_by_zero !== edz) begin errors++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz); end
   endtask
   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
         errors++;
         $display("FAIL reset outputs: got busy=%b done=%b dz=%b q=%h r=%h expected all zero", busy, done, div_by_zero, quotient, remainder);
      end
      reset = 1'b0;
   endtask
   task automatic test_divu();
      check_op("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
      check_op("divu_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34);
      check_op("divu_5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 34);
      check_op("divu_big", 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, 34);
   endtask
   task automatic test_signed();
      check_op("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      check_op("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
      check_op("div_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 34);
      check_op("div_overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 34);
   endtask
   task automatic test_div_by_zero();
      check_op("dbz_unsigned", 32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 2);
      check_op("dbz_signed", 32'hFFFFFFF0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 2);
      check_op("after_dbz", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);
   endtask
   task automatic test_busy_ignore();
      int lat;
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      tests++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
      while (lat < 10) begin @(negedge clk); lat++; end
      dividend = 32'd5; divisor = 32'd1; is_signed = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      tests++;
      if (lat !== 34) begin errors++; $display("FAIL busy_latency: got %0d expected 34", lat); end
      tests++;
      if (quotient !== 32'd100 || remainder !== 32'd0) begin
         errors++; $display("FAIL busy_result: got q=%h r=%h expected q=00000064 r=00000000", quotient, remainder);
      end
      // a start during the done cycle must be dropped
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy=%b done=%b expected 0 0", busy, done); end
   endtask
   task automatic test_reset_mid();
      int lat;
      int seen;
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (lat < 20) begin @(negedge clk); lat++; end
      reset = 1'b1;
      #1;
      tests++;
      if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
         errors++;
         $display("FAIL reset_mid outputs: got busy=%b done=%b dz=%b q=%h r=%h expected all zero", busy, done, div_by_zero, quotient, remainder);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      tests++;
      if (seen !== 0) begin errors++; $display("FAIL reset_mid no_done: got %0d active cycles expected 0", seen); end
      check_op("after_reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
   endtask
   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_div_by_zero();
      test_busy_ignore();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
